// File: rtl/prog_stim_gen.sv
// rtl/prog_stim_gen.sv - multi-channel programmable clock / one-shot stimulus generator
module prog_stim_gen #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 16,
  parameter int RUN_W = 32,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic              cfg_mode,
  input  logic              cfg_init,
  input  logic [CNT_W-1:0]  cfg_delay,
  input  logic [CNT_W-1:0]  cfg_half,
  input  logic [RUN_W-1:0]  run_limit,
  input  logic              start,
  input  logic              abort,
  output logic [NUM_CH-1:0] ch_out,
  output logic              busy,
  output logic              done,
  output logic [RUN_W-1:0]  tick_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CH_W:0] NUM_CH_V = (CH_W + 1)'(NUM_CH);

  state_t state, state_nx;
  logic   run_go;
  logic   cfg_hit;

  logic [NUM_CH-1:0] cfg_mode_r;
  logic [NUM_CH-1:0] cfg_init_r;
  logic [CNT_W-1:0]  cfg_delay_r [NUM_CH];
  logic [CNT_W-1:0]  cfg_half_r  [NUM_CH];

  logic [CNT_W-1:0]  dly_cnt  [NUM_CH];
  logic [CNT_W-1:0]  half_cnt [NUM_CH];
  logic [NUM_CH-1:0] fired;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: if (start) state_nx = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (run_limit != '0 && tick_count == run_limit - RUN_W'(1)) state_nx = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_nx = S_RUN;
      end
      default: state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
    run_go = start && !abort && (state != S_RUN);
  end

  // Widened compare so out-of-range channel indices are rejected for any NUM_CH.
  assign cfg_hit = cfg_we && (state == S_IDLE) && ({1'b0, cfg_ch} < NUM_CH_V);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cfg_mode_r <= '0;
      cfg_init_r <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cfg_delay_r[i] <= '0;
        cfg_half_r[i]  <= '0;
      end
    end else if (cfg_hit) begin
      cfg_mode_r[cfg_ch]  <= cfg_mode;
      cfg_init_r[cfg_ch]  <= cfg_init;
      cfg_delay_r[cfg_ch] <= cfg_delay;
      cfg_half_r[cfg_ch]  <= cfg_half;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ch_out     <= '0;
      tick_count <= '0;
      fired      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        dly_cnt[i]  <= '0;
        half_cnt[i] <= '0;
      end
    end else if (run_go) begin
      ch_out     <= cfg_init_r;
      tick_count <= '0;
      fired      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        dly_cnt[i]  <= cfg_delay_r[i];
        half_cnt[i] <= '0;
      end
    end else if (state_nx == S_IDLE) begin
      ch_out     <= cfg_init_r;
      tick_count <= '0;
    end else if (state == S_RUN) begin
      // The final RUN cycle still applies its channel edges; only the count freezes.
      if (state_nx == S_RUN) tick_count <= tick_count + RUN_W'(1);
      for (int i = 0; i < NUM_CH; i++) begin
        if (!fired[i]) begin
          if (dly_cnt[i] == '0) begin
            fired[i]    <= 1'b1;
            half_cnt[i] <= cfg_half_r[i] - CNT_W'(1);
            if (cfg_mode_r[i])               ch_out[i] <= ~cfg_init_r[i];
            else if (cfg_half_r[i] != '0)    ch_out[i] <= ~ch_out[i];
          end else begin
            dly_cnt[i] <= dly_cnt[i] - CNT_W'(1);
          end
        end else if (!cfg_mode_r[i] && cfg_half_r[i] != '0) begin
          // half_cnt holds H-1 after a toggle so the next edge lands H cycles later.
          if (half_cnt[i] == '0) begin
            ch_out[i]   <= ~ch_out[i];
            half_cnt[i] <= cfg_half_r[i] - CNT_W'(1);
          end else begin
            half_cnt[i] <= half_cnt[i] - CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_stim_gen.sv
// tb/tb_prog_stim_gen.sv - directed self-checking bench for prog_stim_gen
module tb_prog_stim_gen;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic        cfg_mode = 1'b0;
  logic        cfg_init = 1'b0;
  logic [15:0] cfg_delay = '0;
  logic [15:0] cfg_half = '0;
  logic [31:0] run_limit = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;

  logic [3:0]  ch_a;
  logic        busy_a, done_a;
  logic [31:0] tick_a;
  logic [2:0]  ch_b;
  logic        busy_b, done_b;
  logic [7:0]  tick_b;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  prog_stim_gen #(.NUM_CH(4), .CNT_W(16), .RUN_W(32)) dut_a (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_init(cfg_init), .cfg_delay(cfg_delay),
    .cfg_half(cfg_half), .run_limit(run_limit), .start(start), .abort(abort),
    .ch_out(ch_a), .busy(busy_a), .done(done_a), .tick_count(tick_a)
  );

  // Narrow variant: tick counter wrap and a channel index beyond NUM_CH.
  prog_stim_gen #(.NUM_CH(3), .CNT_W(16), .RUN_W(8)) dut_b (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_init(cfg_init), .cfg_delay(cfg_delay),
    .cfg_half(cfg_half), .run_limit(run_limit[7:0]), .start(start), .abort(abort),
    .ch_out(ch_b), .busy(busy_b), .done(done_b), .tick_count(tick_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic m, input logic init,
                     input logic [15:0] d, input logic [15:0] h);
    cfg_we = 1'b1; cfg_ch = ch; cfg_mode = m; cfg_init = init;
    cfg_delay = d; cfg_half = h;
    step(1);
    cfg_we = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic stop();
    abort = 1'b1;
    step(1);
    abort = 1'b0;
  endtask

  initial begin
    // reset state, then reset mid-run
    step(2);
    chk("rst_ch", 32'(ch_a), 32'h0);
    chk("rst_busy", 32'(busy_a), 32'h0);
    chk("rst_done", 32'(done_a), 32'h0);
    chk("rst_tick", tick_a, 32'h0);
    reset = 1'b0;
    step(1);
    cfg(2'd1, 1'b1, 1'b1, 16'd100, 16'd0);
    run_limit = 32'd0;
    go();
    step(37);
    chk("t37_ch", 32'(ch_a), 32'h2);
    chk("t37_tick", tick_a, 32'd37);
    reset = 1'b1;
    #1;
    chk("arst_ch", 32'(ch_a), 32'h0);
    chk("arst_busy", 32'(busy_a), 32'h0);
    chk("arst_tick", tick_a, 32'h0);
    step(1);
    reset = 1'b0;
    step(1);
    chk("post_idle_ch", 32'(ch_a), 32'h0);
    go();
    step(20);
    chk("post_run_ch", 32'(ch_a), 32'h0);
    chk("post_run_busy", 32'(busy_a), 32'h1);
    chk("post_run_tick", tick_a, 32'd20);
    stop();

    // periodic ch0 D=10 H=10, limit 500, with an ignored mid-run write
    cfg(2'd0, 1'b0, 1'b0, 16'd10, 16'd10);
    run_limit = 32'd500;
    go();
    step(3);
    cfg(2'd0, 1'b0, 1'b1, 16'd2, 16'd3);
    step(6);
    chk("p_t10", 32'(ch_a[0]), 32'h0);
    step(1);
    chk("p_t11", 32'(ch_a[0]), 32'h1);
    step(9);
    chk("p_t20", 32'(ch_a[0]), 32'h1);
    step(1);
    chk("p_t21", 32'(ch_a[0]), 32'h0);
    step(10);
    chk("p_t31", 32'(ch_a[0]), 32'h1);
    step(468);
    chk("p_t499_busy", 32'(busy_a), 32'h1);
    chk("p_t499_done", 32'(done_a), 32'h0);
    chk("p_t499_tick", tick_a, 32'd499);
    step(1);
    chk("p_done", 32'(done_a), 32'h1);
    chk("p_done_busy", 32'(busy_a), 32'h0);
    chk("p_done_tick", tick_a, 32'd499);
    chk("p_done_ch0", 32'(ch_a[0]), 32'h1);
    step(5);
    chk("p_hold_tick", tick_a, 32'd499);
    chk("p_hold_ch0", 32'(ch_a[0]), 32'h1);

    // restart from DONE: H=10 timing repeats, then abort at t=100
    go();
    chk("r_busy", 32'(busy_a), 32'h1);
    chk("r_done", 32'(done_a), 32'h0);
    chk("r_tick", tick_a, 32'h0);
    chk("r_ch0", 32'(ch_a[0]), 32'h0);
    step(10);
    chk("r_t10", 32'(ch_a[0]), 32'h0);
    step(1);
    chk("r_t11", 32'(ch_a[0]), 32'h1);
    step(10);
    chk("r_t21", 32'(ch_a[0]), 32'h0);
    step(79);
    chk("r_t100", 32'(ch_a[0]), 32'h1);
    stop();
    chk("ab_busy", 32'(busy_a), 32'h0);
    chk("ab_done", 32'(done_a), 32'h0);
    chk("ab_tick", tick_a, 32'h0);
    chk("ab_ch0", 32'(ch_a[0]), 32'h0);
    start = 1'b1;
    abort = 1'b1;
    step(1);
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", 32'(busy_a), 32'h0);
    step(3);
    chk("sa_busy2", 32'(busy_a), 32'h0);
    chk("sa_tick", tick_a, 32'h0);

    // one-shots: ch1 init=1 D=25, ch2 init=0 D=30
    cfg(2'd1, 1'b1, 1'b1, 16'd25, 16'd0);
    cfg(2'd2, 1'b1, 1'b0, 16'd30, 16'd0);
    chk("os_idle", 32'(ch_a[2:1]), 32'h1);
    run_limit = 32'd61;
    go();
    chk("os_t0", 32'(ch_a[2:1]), 32'h1);
    step(25);
    chk("os_t25", 32'(ch_a[2:1]), 32'h1);
    step(1);
    chk("os_t26", 32'(ch_a[2:1]), 32'h0);
    step(4);
    chk("os_t30", 32'(ch_a[2:1]), 32'h0);
    step(1);
    chk("os_t31", 32'(ch_a[2:1]), 32'h2);
    step(29);
    chk("os_t60_busy", 32'(busy_a), 32'h1);
    step(1);
    chk("os_done", 32'(done_a), 32'h1);
    chk("os_done_ch", 32'(ch_a[2:1]), 32'h2);
    go();
    chk("os_rearm", 32'(ch_a[2:1]), 32'h1);
    stop();

    // free-run, H=1 D=0, tick wrap on the 8-bit variant, out-of-range channel write
    cfg(2'd3, 1'b0, 1'b1, 16'd0, 16'd1);
    cfg(2'd2, 1'b0, 1'b0, 16'd0, 16'd1);
    chk("fr_idle_a", 32'(ch_a), 32'ha);
    chk("fr_idle_b", 32'(ch_b), 32'h2);
    run_limit = 32'd0;
    go();
    for (int k = 0; k < 4; k++) begin
      chk("fr_a_ch3", 32'(ch_a[3]), 32'(k % 2 == 0));
      chk("fr_b_ch2", 32'(ch_b[2]), 32'(k % 2 == 1));
      step(1);
    end
    step(251);
    chk("fr_t255_b", 32'(tick_b), 32'd255);
    chk("fr_t255_a", tick_a, 32'd255);
    step(1);
    chk("fr_wrap_b", 32'(tick_b), 32'd0);
    chk("fr_wrap_busy_b", 32'(busy_b), 32'h1);
    chk("fr_t256_a", tick_a, 32'd256);
    chk("fr_t256_ch_b", 32'(ch_b[2]), 32'h0);
    chk("fr_t256_ch_a", 32'(ch_a[3]), 32'h1);
    step(44);
    chk("fr_t300_done_a", 32'(done_a), 32'h0);
    chk("fr_t300_busy_a", 32'(busy_a), 32'h1);
    chk("fr_t300_done_b", 32'(done_b), 32'h0);
    stop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
